// File: rtl/uart_packet_framer_if.sv
// Buffer-read and transmit handshake bundle between the packet framer and its neighbours.
// master = framer side, slave = caching buffer / uart_tx side.
interface uart_packet_framer_if;
    logic       buf_rd_en;
    logic [7:0] buf_data;
    logic       buf_valid;
    logic       buf_empty;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output buf_rd_en,
        input  buf_data,
        input  buf_valid,
        input  buf_empty,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  buf_rd_en,
        output buf_data,
        output buf_valid,
        output buf_empty,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_packet_framer.sv
// Drains the caching buffer into a staging array and emits framed packets
// (sync, seq, len, payload, xor checksum) towards uart_tx.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for enable and a non-empty buffer
// FILL    | reading bytes into stage[], one outstanding read at most
// SYNC    | presenting SYNC_BYTE
// SEQ     | presenting the sequence number
// LEN     | presenting the payload length
// PAYLOAD | presenting stage[0..fill_cnt-1]
// CSUM    | presenting seq ^ len ^ xor(payload)
module uart_packet_framer #(
    parameter int         PAYLOAD_LEN    = 16,
    parameter int         TIMEOUT_CYCLES = 5000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    uart_packet_framer_if.master bus,
    output logic                 busy,
    output logic [15:0]          pkt_count,
    output logic [7:0]           seq_dbg
);

    localparam int IDX_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       LEN_MAX = 8'(PAYLOAD_LEN);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SYNC,
        SEQ,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    state_t           state;
    logic [7:0]       stage [2**IDX_W];
    logic [7:0]       fill_cnt;
    logic [7:0]       tx_idx;
    logic [7:0]       csum;
    logic [7:0]       seq;
    logic [TMR_W-1:0] timer;
    logic             pending;

    logic             capture;
    logic             timed_out;
    logic             can_read;
    logic [7:0]       stage_rd;

    // pending spans the request cycle and the following data cycle; the
    // buffer answers one cycle after it samples buf_rd_en.
    assign capture   = (state == FILL) && pending && !bus.buf_rd_en && bus.buf_valid;
    assign timed_out = (timer == TMR_MAX);
    assign can_read  = !bus.buf_empty && enable && (fill_cnt < LEN_MAX);
    assign stage_rd  = stage[tx_idx[IDX_W-1:0]];
    assign seq_dbg   = seq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.buf_rd_en <= 1'b0;
            bus.tx_valid  <= 1'b0;
            bus.tx_data   <= 8'h00;
            busy          <= 1'b0;
            pkt_count     <= 16'h0000;
            seq           <= 8'h00;
            fill_cnt      <= 8'h00;
            tx_idx        <= 8'h00;
            csum          <= 8'h00;
            timer         <= '0;
            pending       <= 1'b0;
        end else begin
            bus.buf_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !bus.buf_empty) begin
                        state    <= FILL;
                        busy     <= 1'b1;
                        fill_cnt <= 8'h00;
                        timer    <= '0;
                        pending  <= 1'b0;
                        csum     <= 8'h00;
                    end
                end

                FILL: begin
                    if (capture) begin
                        stage[fill_cnt[IDX_W-1:0]] <= bus.buf_data;
                        fill_cnt <= fill_cnt + 8'd1;
                        csum     <= csum ^ bus.buf_data;
                        timer    <= '0;
                    end else if (!timed_out) begin
                        timer <= timer + TMR_ONE;
                    end

                    if (pending) begin
                        if (!bus.buf_rd_en)
                            pending <= 1'b0;
                    end else if (fill_cnt == LEN_MAX ||
                                 (fill_cnt != 8'h00 && (timed_out || !enable))) begin
                        state <= SYNC;
                    end else if (fill_cnt == 8'h00 && !enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (can_read) begin
                        bus.buf_rd_en <= 1'b1;
                        pending       <= 1'b1;
                    end
                end

                SYNC: begin
                    if (!bus.tx_valid) begin
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= SYNC_BYTE;
                    end else if (bus.tx_ready) begin
                        bus.tx_data <= seq;
                        state       <= SEQ;
                    end
                end

                SEQ: begin
                    if (bus.tx_ready) begin
                        bus.tx_data <= fill_cnt;
                        state       <= LEN;
                    end
                end

                LEN: begin
                    if (bus.tx_ready) begin
                        bus.tx_data <= stage[0];
                        tx_idx      <= 8'd1;
                        state       <= PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    if (bus.tx_ready) begin
                        if (tx_idx == fill_cnt) begin
                            bus.tx_data <= seq ^ fill_cnt ^ csum;
                            state       <= CSUM;
                        end else begin
                            bus.tx_data <= stage_rd;
                            tx_idx      <= tx_idx + 8'd1;
                        end
                    end
                end

                CSUM: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        seq          <= seq + 8'd1;
                        pkt_count    <= pkt_count + 16'd1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    bus.tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_packet_framer.sv
// Scoreboard bench for uart_packet_framer: buffer model feeds bytes, expected
// packets are queued at stimulus time and compared against the transmitted stream.
module tb_uart_packet_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [15:0] pkt_count;
    logic [7:0]  seq_dbg;

    uart_packet_framer_if bus_if ();

    uart_packet_framer #(
        .PAYLOAD_LEN   (4),
        .TIMEOUT_CYCLES(16),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus_if.master),
        .busy     (busy),
        .pkt_count(pkt_count),
        .seq_dbg  (seq_dbg)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] byte_q_t [$];
    byte_q_t buf_q;
    byte_q_t exp_q;
    byte_q_t obs_q;

    int          checks   = 0;
    int          failures = 0;
    int          rd_cnt   = 0;
    int          txv_cnt  = 0;
    logic [7:0]  model_seq  = 8'h00;
    logic [15:0] model_pkts = 16'h0000;

    // caching buffer: data and valid one cycle after a read of a non-empty buffer
    always @(posedge clk) begin
        bus_if.buf_valid <= 1'b0;
        if (bus_if.buf_rd_en === 1'b1 && buf_q.size() > 0) begin
            bus_if.buf_data  <= buf_q.pop_front();
            bus_if.buf_valid <= 1'b1;
        end
        bus_if.buf_empty <= (buf_q.size() == 0);
    end

    always @(negedge clk) begin
        #3;
        if (bus_if.tx_valid === 1'b1 && bus_if.tx_ready === 1'b1)
            obs_q.push_back(bus_if.tx_data);
        if (bus_if.buf_rd_en === 1'b1) rd_cnt++;
        if (bus_if.tx_valid === 1'b1) txv_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        buf_q.delete();
        exp_q.delete();
        obs_q.delete();
        model_seq  = 8'h00;
        model_pkts = 16'h0000;
    endtask

    // bytes packed first-byte-in-MSB; fills the buffer and queues the framed packet
    task automatic load_packet(input logic [31:0] bytes, input int n);
        logic [7:0] b;
        logic [7:0] c;
        c = model_seq ^ 8'(n);
        exp_q.push_back(8'hA5);
        exp_q.push_back(model_seq);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            b = bytes[31-8*i -: 8];
            buf_q.push_back(b);
            exp_q.push_back(b);
            c = c ^ b;
        end
        exp_q.push_back(c);
        model_seq  = model_seq + 8'd1;
        model_pkts = model_pkts + 16'd1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        enable    = 1'b0;
        bus_if.tx_ready = 1'b1;
        tick(2);
        checks++; if (bus_if.tx_valid !== 1'b0)  begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus_if.tx_valid); end
        checks++; if (bus_if.tx_data !== 8'h00)  begin failures++; $display("FAIL reset_tx_data got=%02h exp=00", bus_if.tx_data); end
        checks++; if (bus_if.buf_rd_en !== 1'b0) begin failures++; $display("FAIL reset_buf_rd_en got=%b exp=0", bus_if.buf_rd_en); end
        checks++; if (busy !== 1'b0)             begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (pkt_count !== 16'h0000)    begin failures++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (seq_dbg !== 8'h00)         begin failures++; $display("FAIL reset_seq got=%02h exp=00", seq_dbg); end
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_full_packet(input logic [31:0] bytes, input string name);
        bit ok;
        logic [7:0] e, o;
        enable = 1'b1;
        bus_if.tx_ready = 1'b1;
        load_packet(bytes, 4);
        wait_obs(8, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL %s_timeout got=%0d bytes exp=8", name, obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL %s_byte got=%02h exp=%02h", name, o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin failures++; $display("FAIL %s_count left_exp=%0d left_obs=%0d", name, exp_q.size(), obs_q.size()); end
        checks++; if (pkt_count !== model_pkts) begin failures++; $display("FAIL %s_pkt_count got=%0d exp=%0d", name, pkt_count, model_pkts); end
        checks++; if (seq_dbg !== model_seq)    begin failures++; $display("FAIL %s_seq got=%02h exp=%02h", name, seq_dbg, model_seq); end
        checks++; if (busy !== 1'b0)            begin failures++; $display("FAIL %s_busy got=%b exp=0", name, busy); end
    endtask

    task automatic test_timeout_flush();
        bit ok;
        int last_v;
        int first_tx;
        logic [7:0] e, o;
        apply_reset();
        enable = 1'b1;
        bus_if.tx_ready = 1'b1;
        load_packet(32'hAABB_0000, 2);
        last_v   = -1;
        first_tx = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_if.buf_valid === 1'b1) last_v = i;
            if (bus_if.tx_valid === 1'b1) begin
                first_tx = i;
                break;
            end
        end
        // 16 idle cycles to saturate the timer, then the exit and tx_valid edges
        checks++; if (first_tx < 0 || last_v < 0 || (first_tx - last_v) < 17 || (first_tx - last_v) > 20) begin
            failures++; $display("FAIL timeout_delay got=%0d exp=17..20", first_tx - last_v);
        end
        wait_obs(6, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_bytes got=%0d exp=6", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL timeout_byte got=%02h exp=%02h", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin failures++; $display("FAIL timeout_count left_exp=%0d left_obs=%0d", exp_q.size(), obs_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        logic [7:0] e, o;
        enable = 1'b1;
        bus_if.tx_ready = 1'b0;
        load_packet(32'h5AC3_0FF0, 4);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_if.tx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin failures++; $display("FAIL stall_start got=%b exp=1", bus_if.tx_valid); end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'hA5 || busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", bad); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stall_leak got=%0d bytes exp=0", obs_q.size()); end
        bus_if.tx_ready = 1'b1;
        tick(8);
        checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL stall_bubble got=%0d bytes in 8 cycles exp=8", obs_q.size()); end
        checks++; if (bus_if.tx_valid !== 1'b0) begin failures++; $display("FAIL stall_end_valid got=%b exp=0", bus_if.tx_valid); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL stall_byte got=%02h exp=%02h", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin failures++; $display("FAIL stall_count left_exp=%0d left_obs=%0d", exp_q.size(), obs_q.size()); end
        checks++; if (pkt_count !== model_pkts) begin failures++; $display("FAIL stall_pkt_count got=%0d exp=%0d", pkt_count, model_pkts); end
    endtask

    task automatic test_reset_midpacket();
        bit ok;
        logic [7:0] e, o;
        enable = 1'b1;
        bus_if.tx_ready = 1'b1;
        buf_q.push_back(8'hDE);
        buf_q.push_back(8'hAD);
        buf_q.push_back(8'hBE);
        buf_q.push_back(8'hEF);
        wait_obs(4, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_reach_payload got=%0d bytes exp=4", obs_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus_if.tx_valid !== 1'b0) begin failures++; $display("FAIL abort_tx_valid got=%b exp=0", bus_if.tx_valid); end
        checks++; if (busy !== 1'b0)            begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (pkt_count !== 16'h0000)   begin failures++; $display("FAIL abort_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (seq_dbg !== 8'h00)        begin failures++; $display("FAIL abort_seq got=%02h exp=00", seq_dbg); end
        rst = 1'b0;
        obs_q.delete();
        model_seq  = 8'h00;
        model_pkts = 16'h0000;
        load_packet(32'h0102_0304, 4);
        wait_obs(8, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_next_bytes got=%0d exp=8", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL abort_next_byte got=%02h exp=%02h", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin failures++; $display("FAIL abort_next_count left_exp=%0d left_obs=%0d", exp_q.size(), obs_q.size()); end
        checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL abort_next_pkt_count got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_enable();
        bit ok;
        int rd0;
        int v0;
        int nval;
        int k;
        logic [7:0] e, o;
        @(negedge clk);
        enable = 1'b0;
        bus_if.tx_ready = 1'b1;
        rd0 = rd_cnt;
        v0  = txv_cnt;
        load_packet(32'hC1C2_C300, 3);
        tick(60);
        checks++; if (rd_cnt != rd0)  begin failures++; $display("FAIL disabled_reads got=%0d exp=0", rd_cnt - rd0); end
        checks++; if (txv_cnt != v0)  begin failures++; $display("FAIL disabled_tx_valid got=%0d exp=0", txv_cnt - v0); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL disabled_busy got=%b exp=0", busy); end
        enable = 1'b1;
        nval = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_if.buf_valid === 1'b1) nval++;
            if (nval == 3) break;
        end
        checks++; if (nval != 3) begin failures++; $display("FAIL partial_captures got=%0d exp=3", nval); end
        @(negedge clk);
        enable = 1'b0;
        k = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus_if.tx_valid === 1'b1) begin
                k = i;
                break;
            end
        end
        // well inside the 16-cycle timeout, so the flush came from enable dropping
        checks++; if (k < 1 || k > 6) begin failures++; $display("FAIL partial_flush_delay got=%0d exp=1..6", k); end
        wait_obs(7, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL partial_bytes got=%0d exp=7", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL partial_byte got=%02h exp=%02h", o, e); end
        end
        checks++; if (exp_q.size() != 0 || obs_q.size() != 0) begin failures++; $display("FAIL partial_count left_exp=%0d left_obs=%0d", exp_q.size(), obs_q.size()); end
        tick(3);
        checks++; if (busy !== 1'b0)            begin failures++; $display("FAIL partial_idle got=%b exp=0", busy); end
        checks++; if (pkt_count !== model_pkts) begin failures++; $display("FAIL partial_pkt_count got=%0d exp=%0d", pkt_count, model_pkts); end
    endtask

    initial begin
        rst             = 1'b1;
        enable          = 1'b0;
        bus_if.tx_ready = 1'b1;
        test_reset();
        test_full_packet(32'h1122_3344, "first_pkt");
        test_full_packet(32'h5566_7788, "second_pkt");
        test_timeout_flush();
        test_backpressure();
        test_reset_midpacket();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_packet_framer.md
Name: uart_packet_framer

Overview:
Framing stage between the 512-byte caching buffer and uart_tx. It drains bytes from the buffer into a staging array and emits framed packets to the transmitter: sync byte, sequence number, length, payload, then an XOR checksum. The host can then resynchronise and detect dropped or corrupted data on the 100 kbaud return link.

Parameters:
PAYLOAD_LEN, 16, maximum payload bytes per packet; legal range 1..255.
TIMEOUT_CYCLES, 5000, consecutive idle cycles in FILL before a partial packet is flushed (100 us at 50 MHz); must be ≥ 2.
SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
clk  in  1  system clock (CLOCK_50)
rst  in  1  synchronous, active-high reset
enable  in  1  permits starting new packets (SW[8])
buf_rd_en  out  1  one-cycle read request to the buffer
buf_data  in  8  buffer read data, valid when buf_valid=1
buf_valid  in  1  asserted exactly one cycle after a buf_rd_en to a non-empty buffer
buf_empty  in  1  buffer empty flag
tx_data  out  8  byte to uart_tx
tx_valid  out  1  tx_data is valid
tx_ready  in  1  uart_tx accepts; a byte transfers on any cycle with tx_valid && tx_ready
busy  out  1  high in every state except IDLE
pkt_count  out  16  completed packets, wraps at 65535→0
seq_dbg  out  8  sequence number of the next packet

Behaviour:
- Reset (synchronous, all outputs): buf_rd_en=0, tx_valid=0, tx_data=0, busy=0, pkt_count=0, seq=0; state=IDLE. Staging contents are don't-care.
- Reset asserted mid-packet aborts the packet immediately. The next packet restarts at seq 0.
- States: IDLE, FILL, SYNC, SEQ, LEN, PAYLOAD, CSUM.
- IDLE → FILL when enable=1 && buf_empty=0. fill_cnt, timer, pending and csum are cleared.
- FILL, read issue:
  - Pulse buf_rd_en (registered, one cycle) when pending=0, buf_empty=0, fill_cnt < PAYLOAD_LEN and enable=1.
  - Issuing a read sets pending. At most one read is outstanding.
- FILL, read completion:
  - In the cycle after a read, pending clears.
  - If buf_valid=1: store buf_data at stage[fill_cnt], fill_cnt++, csum ^= buf_data, timer=0.
  - If buf_valid=0 (empty race): discard, no count.
- FILL, timer: increments each FILL cycle without a capture, saturating at TIMEOUT_CYCLES.
- FILL exits, evaluated only when pending=0:
  - fill_cnt == PAYLOAD_LEN → SYNC.
  - fill_cnt > 0 && (timer == TIMEOUT_CYCLES || enable == 0) → SYNC.
  - fill_cnt == 0 && enable == 0 → IDLE.
  - fill_cnt == 0 && timer == TIMEOUT_CYCLES → stay in FILL.
- Transmit sequence: SYNC sends SYNC_BYTE, SEQ sends seq, LEN sends fill_cnt, PAYLOAD sends stage[0..fill_cnt-1] in order, CSUM sends seq ^ fill_cnt ^ XOR(payload). SYNC_BYTE is excluded from the checksum.
- Transmit handshake:
  - On entry to SYNC, tx_valid goes 1 with tx_data=SYNC_BYTE on the next edge.
  - tx_data is held stable while tx_valid && !tx_ready.
  - On an accept edge, tx_data loads the next byte and tx_valid stays 1, so back-to-back bytes carry no bubble.
  - The accept edge in CSUM: tx_valid → 0, seq++ (wraps 255→0), pkt_count++, state → IDLE.
- No buffer reads occur outside FILL.
- enable deassert outside FILL has no effect on the packet in flight.
- Packet length on the wire is fill_cnt + 4 bytes; the minimum is 5 bytes (1-byte payload).

Test Plan:
1. PAYLOAD_LEN=4, buffer holds 11 22 33 44, enable=1, tx_ready=1 → tx bytes A5 00 04 11 22 33 44 40; then pkt_count=1, seq_dbg=01, busy=0.
2. Follow-up with buffer 55 66 77 88 → A5 01 04 55 66 77 88 C9; pkt_count=2.
3. Buffer holds AA BB then stays empty, TIMEOUT_CYCLES=16 → flush 16 cycles after the last capture; bytes A5 00 02 AA BB 13.
4. Hold tx_ready=0 for 100 cycles during SYNC → tx_valid=1 and tx_data=A5 stable throughout. Then tx_ready=1 → remaining bytes follow with no bubble.
5. Assert rst for one cycle during PAYLOAD → next edge tx_valid=0, busy=0, pkt_count=0. The next packet starts A5 00.
6. enable=0 with buffer non-empty → buf_rd_en never pulses, tx_valid stays 0. enable=0 during FILL with fill_cnt=3 → a 3-byte packet is sent, then IDLE.
